soc_bus_arbiter: RTL and testbench

SOC_BUS_ARBITER -- requirements
Module: soc_bus_arbiter

---
 rtl/soc_bus_arbiter.sv | 52 +++++
 tb/tb_soc_bus_arbiter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/soc_bus_arbiter.sv
// soc_bus_arbiter: CPU/DMA shared-bus arbiter; DMA bursts of up to MAX_BURST accepts, then a forced CPU slot
module soc_bus_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_rdy,
  output logic [7:0]  cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  output logic        dma_gnt,
  output logic        dma_ack,
  output logic [7:0]  dma_rdata,
  output logic [15:0] bus_addr,
  output logic        bus_we,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata
);
  typedef enum logic [1:0] {S_CPU, S_DMA, S_TURN} state_t;
  localparam logic [7:0] MB = 8'(MAX_BURST);
  state_t state, state_nx;
  logic [7:0] bcnt, bcnt_nx;
  logic acc;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= S_CPU;
      bcnt <= '0;
      dma_ack <= 1'b0;
    end else begin
      state <= state_nx;
      bcnt <= bcnt_nx;
      dma_ack <= acc;
    end
  // grant depends on state only, so dma_req never combinationally reaches dma_gnt
  always_comb begin
    cpu_rdy = state == S_CPU;
    dma_gnt = state == S_DMA;
    acc = dma_gnt && dma_req;
    bus_addr = acc ? dma_addr : cpu_addr;
    bus_wdata = acc ? dma_wdata : cpu_wdata;
    bus_we = cpu_rdy ? cpu_we : acc && dma_we;
    cpu_rdata = bus_rdata;
    dma_rdata = bus_rdata;
    bcnt_nx = cpu_rdy ? 8'd0 : (acc && bcnt < MB) ? bcnt + 8'd1 : bcnt;
    state_nx = cpu_rdy ? (dma_req ? S_DMA : S_CPU) : !acc ? S_CPU : (bcnt_nx == MB) ? S_TURN : S_DMA;
  end
endmodule

// File: tb/tb_soc_bus_arbiter.sv
// tb_soc_bus_arbiter: scenario tasks with inline checks; DMA read data tracked through a scoreboard queue
module tb_soc_bus_arbiter;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [15:0] cpu_addr = '0, dma_addr = '0, bus_addr;
  logic cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
  logic [7:0] cpu_wdata = '0, dma_wdata = '0, bus_rdata = '0;
  logic cpu_rdy, dma_gnt, dma_ack, bus_we;
  logic [7:0] cpu_rdata, dma_rdata, bus_wdata;
  logic [3:0] obs;
  logic [7:0] q[$];
  int vec = 0, bad = 0;
  always #5 clk = ~clk;
  assign obs = {cpu_rdy, dma_gnt, dma_ack, bus_we};
  soc_bus_arbiter #(.MAX_BURST(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata), .cpu_rdy(cpu_rdy), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .bus_addr(bus_addr), .bus_we(bus_we), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
  );
  task automatic nx;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    cpu_addr = 16'h0200; cpu_we = 1'b1; cpu_wdata = 8'h55; dma_req = 1'b1;
    #3;
    vec++; if (obs !== 4'b1001) begin bad++; $display("FAIL rst_flags: got %b want 1001", obs); end
    vec++; if (bus_addr !== 16'h0200 || bus_wdata !== 8'h55) begin bad++; $display("FAIL rst_bus: got %h/%h want 0200/55", bus_addr, bus_wdata); end
    dma_req = 1'b0;
    nx;
    reset_n = 1'b1;
  endtask
  task automatic test_cpu_only;
    cpu_addr = 16'h0200; cpu_we = 1'b1; cpu_wdata = 8'h55; dma_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus_rdata = 8'($urandom);
      #2;
      vec++; if (obs !== 4'b1001) begin bad++; $display("FAIL cpu_flags[%0d]: got %b want 1001", i, obs); end
      vec++; if (bus_addr !== 16'h0200 || bus_wdata !== 8'h55) begin bad++; $display("FAIL cpu_bus[%0d]: got %h/%h want 0200/55", i, bus_addr, bus_wdata); end
      vec++; if (cpu_rdata !== bus_rdata) begin bad++; $display("FAIL cpu_rdata[%0d]: got %h want %h", i, cpu_rdata, bus_rdata); end
      nx;
    end
  endtask
  task automatic test_single_read;
    logic [7:0] rd;
    cpu_addr = 16'h0200; cpu_we = 1'b1; cpu_wdata = 8'h55;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h1234; dma_wdata = 8'h00;
    #2;
    vec++; if (obs !== 4'b1001) begin bad++; $display("FAIL sr_c0: got %b want 1001", obs); end
    nx;
    #2;
    vec++; if (obs !== 4'b0100 || bus_addr !== 16'h1234) begin bad++; $display("FAIL sr_c1: got %b/%h want 0100/1234", obs, bus_addr); end
    q.push_back(8'($urandom));
    nx;
    dma_req = 1'b0;
    rd = q.pop_front();
    bus_rdata = rd;
    #2;
    vec++; if (obs !== 4'b0110 || bus_addr !== 16'h0200) begin bad++; $display("FAIL sr_c2: got %b/%h want 0110/0200", obs, bus_addr); end
    vec++; if (dma_rdata !== rd) begin bad++; $display("FAIL sr_rdata: got %h want %h", dma_rdata, rd); end
    nx;
    #2;
    vec++; if (obs !== 4'b1001) begin bad++; $display("FAIL sr_c3: got %b want 1001", obs); end
    nx;
  endtask
  task automatic test_dma_write;
    cpu_addr = 16'h0200; cpu_we = 1'b1; cpu_wdata = 8'h55;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0300; dma_wdata = 8'hA5;
    #2;
    vec++; if (obs !== 4'b1001 || bus_addr !== 16'h0200 || bus_wdata !== 8'h55) begin bad++; $display("FAIL wr_c0: got %b/%h/%h want 1001/0200/55", obs, bus_addr, bus_wdata); end
    nx;
    #2;
    vec++; if (obs !== 4'b0101 || bus_addr !== 16'h0300 || bus_wdata !== 8'hA5) begin bad++; $display("FAIL wr_c1: got %b/%h/%h want 0101/0300/a5", obs, bus_addr, bus_wdata); end
    nx;
    dma_req = 1'b0;
    #2;
    vec++; if (obs !== 4'b0110 || bus_addr !== 16'h0200) begin bad++; $display("FAIL wr_idle: got %b/%h want 0110/0200", obs, bus_addr); end
    nx;
    #2;
    vec++; if (obs !== 4'b1001) begin bad++; $display("FAIL wr_c3: got %b want 1001", obs); end
    nx;
  endtask
  task automatic test_burst;
    int acc_n = 0, ack_n = 0, p;
    logic [7:0] rd = '0;
    logic [15:0] ea;
    cpu_addr = 16'h0210; cpu_we = 1'b1; cpu_wdata = 8'h3c; dma_we = 1'b0;
    for (int k = 0; k < 13; k++) begin
      p = k % 6;
      dma_req = 1'b1;
      dma_addr = 16'h4000 + 16'(k);
      if (p >= 2) begin
        rd = q.size() != 0 ? q.pop_front() : 8'h00;
        bus_rdata = rd;
      end
      #2;
      ea = (p >= 1 && p <= 4) ? dma_addr : cpu_addr;
      vec++; if (obs !== {p == 0, p >= 1 && p <= 4, p >= 2, p == 0}) begin bad++; $display("FAIL burst_flags[%0d]: got %b want %b", k, obs, {p == 0, p >= 1 && p <= 4, p >= 2, p == 0}); end
      vec++; if (bus_addr !== ea) begin bad++; $display("FAIL burst_addr[%0d]: got %h want %h", k, bus_addr, ea); end
      if (p >= 2) begin
        vec++; if (dma_rdata !== rd) begin bad++; $display("FAIL burst_rdata[%0d]: got %h want %h", k, dma_rdata, rd); end
      end
      if (p >= 1 && p <= 4) q.push_back(8'($urandom));
      acc_n += int'(dma_gnt && dma_req);
      ack_n += int'(dma_ack);
      nx;
    end
    dma_req = 1'b0;
    #2;
    vec++; if (obs !== 4'b0100) begin bad++; $display("FAIL burst_tail: got %b want 0100", obs); end
    ack_n += int'(dma_ack);
    vec++; if (acc_n !== 8 || ack_n !== acc_n) begin bad++; $display("FAIL burst_count: got acc %0d ack %0d want 8/8", acc_n, ack_n); end
    nx;
  endtask
  task automatic test_reset_mid_burst;
    cpu_addr = 16'h0220; cpu_we = 1'b0; dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h5000;
    #2;
    vec++; if (obs !== 4'b1000) begin bad++; $display("FAIL rm_c0: got %b want 1000", obs); end
    nx;
    #2;
    vec++; if (obs !== 4'b0100) begin bad++; $display("FAIL rm_a1: got %b want 0100", obs); end
    nx;
    #2;
    vec++; if (obs !== 4'b0110) begin bad++; $display("FAIL rm_a2: got %b want 0110", obs); end
    reset_n = 1'b0;
    #1;
    vec++; if (obs !== 4'b1000) begin bad++; $display("FAIL rm_async: got %b want 1000", obs); end
    q.delete();
    nx;
    #2;
    vec++; if (obs !== 4'b1000) begin bad++; $display("FAIL rm_held: got %b want 1000", obs); end
    reset_n = 1'b1;
    nx;
    for (int i = 0; i < 4; i++) begin
      #2;
      vec++; if (obs !== {2'b01, i != 0, 1'b0}) begin bad++; $display("FAIL rm_acc[%0d]: got %b want %b", i, obs, {2'b01, i != 0, 1'b0}); end
      nx;
    end
    dma_req = 1'b0;
    #2;
    vec++; if (obs !== 4'b0010) begin bad++; $display("FAIL rm_turn: got %b want 0010", obs); end
    nx;
    #2;
    vec++; if (obs !== 4'b1000) begin bad++; $display("FAIL rm_cpu: got %b want 1000", obs); end
    nx;
  endtask
  initial begin
    test_reset;
    test_cpu_only;
    test_single_read;
    test_dma_write;
    test_burst;
    test_reset_mid_burst;
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
